// File: rtl/ysyx_24110006_axi_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4 arbiter for single-beat transfers.
// One transaction is outstanding at a time. Writes (LSU only) beat reads.
// Simultaneous reads alternate between the two masters.
// The granted master's channels are wired combinationally to the slave port.
module ysyx_24110006_axi_arbiter (
    input  logic        i_clock,
    input  logic        i_reset_n,
    // IFU read
    input  logic [31:0] i_ifu_araddr,
    input  logic [2:0]  i_ifu_arsize,
    input  logic        i_ifu_arvalid,
    output logic        o_ifu_arready,
    output logic [31:0] o_ifu_rdata,
    output logic [1:0]  o_ifu_rresp,
    output logic        o_ifu_rvalid,
    output logic        o_ifu_rlast,
    input  logic        i_ifu_rready,
    // LSU read
    input  logic [31:0] i_lsu_araddr,
    input  logic [2:0]  i_lsu_arsize,
    input  logic        i_lsu_arvalid,
    output logic        o_lsu_arready,
    output logic [31:0] o_lsu_rdata,
    output logic [1:0]  o_lsu_rresp,
    output logic        o_lsu_rvalid,
    output logic        o_lsu_rlast,
    input  logic        i_lsu_rready,
    // LSU write
    input  logic [31:0] i_lsu_awaddr,
    input  logic [2:0]  i_lsu_awsize,
    input  logic        i_lsu_awvalid,
    output logic        o_lsu_awready,
    input  logic [31:0] i_lsu_wdata,
    input  logic [3:0]  i_lsu_wstrb,
    input  logic        i_lsu_wvalid,
    output logic        o_lsu_wready,
    output logic [1:0]  o_lsu_bresp,
    output logic        o_lsu_bvalid,
    input  logic        i_lsu_bready,
    // slave AR / R
    output logic [31:0] o_s_araddr,
    output logic [2:0]  o_s_arsize,
    output logic        o_s_arvalid,
    output logic [3:0]  o_s_arid,
    output logic [7:0]  o_s_arlen,
    output logic [1:0]  o_s_arburst,
    input  logic        i_s_arready,
    input  logic [31:0] i_s_rdata,
    input  logic [1:0]  i_s_rresp,
    input  logic        i_s_rvalid,
    input  logic        i_s_rlast,
    input  logic [3:0]  i_s_rid,
    output logic        o_s_rready,
    // slave AW / W / B
    output logic [31:0] o_s_awaddr,
    output logic [2:0]  o_s_awsize,
    output logic        o_s_awvalid,
    output logic [3:0]  o_s_awid,
    output logic [7:0]  o_s_awlen,
    output logic [1:0]  o_s_awburst,
    input  logic        i_s_awready,
    output logic [31:0] o_s_wdata,
    output logic [3:0]  o_s_wstrb,
    output logic        o_s_wvalid,
    output logic        o_s_wlast,
    input  logic        i_s_wready,
    input  logic [1:0]  i_s_bresp,
    input  logic        i_s_bvalid,
    input  logic [3:0]  i_s_bid,
    output logic        o_s_bready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_t;

    state_t state_reg;
    logic   last_rd_reg;   // 0: IFU was served last, 1: LSU was served last
    logic   aw_done_reg;   // AW already accepted in the current write
    logic   w_done_reg;    // W already accepted in the current write

    // Response ids are not needed: only one transaction is ever in flight.
    logic unused_ids;
    assign unused_ids = ^{i_s_rid, i_s_bid};

    logic aw_fire;
    logic w_fire;
    assign aw_fire = i_lsu_awvalid && !aw_done_reg && i_s_awready;
    assign w_fire  = i_lsu_wvalid && !w_done_reg && i_s_wready;

    // Arbitration, completion tracking and round-robin history.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= IDLE;
            last_rd_reg <= 1'b1;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    aw_done_reg <= 1'b0;
                    w_done_reg  <= 1'b0;
                    if (i_lsu_awvalid)
                        state_reg <= LSU_WR;
                    else if (i_ifu_arvalid && i_lsu_arvalid)
                        state_reg <= last_rd_reg ? IFU_RD : LSU_RD;
                    else if (i_ifu_arvalid)
                        state_reg <= IFU_RD;
                    else if (i_lsu_arvalid)
                        state_reg <= LSU_RD;
                end
                IFU_RD: begin
                    if (i_s_rvalid && i_ifu_rready) begin
                        state_reg   <= IDLE;
                        last_rd_reg <= 1'b0;
                    end
                end
                LSU_RD: begin
                    if (i_s_rvalid && i_lsu_rready) begin
                        state_reg   <= IDLE;
                        last_rd_reg <= 1'b1;
                    end
                end
                LSU_WR: begin
                    if (aw_fire)
                        aw_done_reg <= 1'b1;
                    if (w_fire)
                        w_done_reg <= 1'b1;
                    if (i_s_bvalid && i_lsu_bready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Channel routing: everything quiet unless a master holds the grant.
    always_comb begin
        o_ifu_arready = 1'b0;
        o_ifu_rdata   = 32'd0;
        o_ifu_rresp   = 2'd0;
        o_ifu_rvalid  = 1'b0;
        o_ifu_rlast   = 1'b0;
        o_lsu_arready = 1'b0;
        o_lsu_rdata   = 32'd0;
        o_lsu_rresp   = 2'd0;
        o_lsu_rvalid  = 1'b0;
        o_lsu_rlast   = 1'b0;
        o_lsu_awready = 1'b0;
        o_lsu_wready  = 1'b0;
        o_lsu_bresp   = 2'd0;
        o_lsu_bvalid  = 1'b0;
        o_s_araddr    = 32'd0;
        o_s_arsize    = 3'd0;
        o_s_arvalid   = 1'b0;
        o_s_arid      = 4'd0;
        o_s_arlen     = 8'd0;
        o_s_arburst   = 2'd0;
        o_s_rready    = 1'b0;
        o_s_awaddr    = 32'd0;
        o_s_awsize    = 3'd0;
        o_s_awvalid   = 1'b0;
        o_s_awid      = 4'd0;
        o_s_awlen     = 8'd0;
        o_s_awburst   = 2'd0;
        o_s_wdata     = 32'd0;
        o_s_wstrb     = 4'd0;
        o_s_wvalid    = 1'b0;
        o_s_wlast     = 1'b0;
        o_s_bready    = 1'b0;
        case (state_reg)
            IFU_RD: begin
                o_s_araddr    = i_ifu_araddr;
                o_s_arsize    = i_ifu_arsize;
                o_s_arvalid   = i_ifu_arvalid;
                o_s_arid      = 4'd0;
                o_s_arburst   = 2'b01;
                o_ifu_arready = i_s_arready;
                o_ifu_rdata   = i_s_rdata;
                o_ifu_rresp   = i_s_rresp;
                o_ifu_rvalid  = i_s_rvalid;
                o_ifu_rlast   = i_s_rlast;
                o_s_rready    = i_ifu_rready;
            end
            LSU_RD: begin
                o_s_araddr    = i_lsu_araddr;
                o_s_arsize    = i_lsu_arsize;
                o_s_arvalid   = i_lsu_arvalid;
                o_s_arid      = 4'd1;
                o_s_arburst   = 2'b01;
                o_lsu_arready = i_s_arready;
                o_lsu_rdata   = i_s_rdata;
                o_lsu_rresp   = i_s_rresp;
                o_lsu_rvalid  = i_s_rvalid;
                o_lsu_rlast   = i_s_rlast;
                o_s_rready    = i_lsu_rready;
            end
            LSU_WR: begin
                // AW and W complete independently; once a channel has
                // handshaken it is masked so it cannot be issued twice.
                o_s_awaddr    = i_lsu_awaddr;
                o_s_awsize    = i_lsu_awsize;
                o_s_awvalid   = i_lsu_awvalid && !aw_done_reg;
                o_s_awid      = 4'd1;
                o_s_awburst   = 2'b01;
                o_lsu_awready = i_s_awready && !aw_done_reg;
                o_s_wdata     = i_lsu_wdata;
                o_s_wstrb     = i_lsu_wstrb;
                o_s_wvalid    = i_lsu_wvalid && !w_done_reg;
                o_s_wlast     = 1'b1;
                o_lsu_wready  = i_s_wready && !w_done_reg;
                o_lsu_bresp   = i_s_bresp;
                o_lsu_bvalid  = i_s_bvalid;
                o_s_bready    = i_lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// Scoreboard bench for the IFU/LSU AXI arbiter: master agents, a slave model,
// a reference ordering model and a monitor that checks every handshake.
module tb_ysyx_24110006_axi_arbiter;

    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b1;
    logic [31:0] i_ifu_araddr = '0;
    logic [2:0]  i_ifu_arsize = '0;
    logic        i_ifu_arvalid = 1'b0;
    logic        o_ifu_arready;
    logic [31:0] o_ifu_rdata;
    logic [1:0]  o_ifu_rresp;
    logic        o_ifu_rvalid;
    logic        o_ifu_rlast;
    logic        i_ifu_rready = 1'b0;
    logic [31:0] i_lsu_araddr = '0;
    logic [2:0]  i_lsu_arsize = '0;
    logic        i_lsu_arvalid = 1'b0;
    logic        o_lsu_arready;
    logic [31:0] o_lsu_rdata;
    logic [1:0]  o_lsu_rresp;
    logic        o_lsu_rvalid;
    logic        o_lsu_rlast;
    logic        i_lsu_rready = 1'b0;
    logic [31:0] i_lsu_awaddr = '0;
    logic [2:0]  i_lsu_awsize = '0;
    logic        i_lsu_awvalid = 1'b0;
    logic        o_lsu_awready;
    logic [31:0] i_lsu_wdata = '0;
    logic [3:0]  i_lsu_wstrb = '0;
    logic        i_lsu_wvalid = 1'b0;
    logic        o_lsu_wready;
    logic [1:0]  o_lsu_bresp;
    logic        o_lsu_bvalid;
    logic        i_lsu_bready = 1'b0;
    logic [31:0] o_s_araddr;
    logic [2:0]  o_s_arsize;
    logic        o_s_arvalid;
    logic [3:0]  o_s_arid;
    logic [7:0]  o_s_arlen;
    logic [1:0]  o_s_arburst;
    logic        i_s_arready = 1'b0;
    logic [31:0] i_s_rdata = '0;
    logic [1:0]  i_s_rresp = '0;
    logic        i_s_rvalid = 1'b0;
    logic        i_s_rlast = 1'b0;
    logic [3:0]  i_s_rid = '0;
    logic        o_s_rready;
    logic [31:0] o_s_awaddr;
    logic [2:0]  o_s_awsize;
    logic        o_s_awvalid;
    logic [3:0]  o_s_awid;
    logic [7:0]  o_s_awlen;
    logic [1:0]  o_s_awburst;
    logic        i_s_awready = 1'b0;
    logic [31:0] o_s_wdata;
    logic [3:0]  o_s_wstrb;
    logic        o_s_wvalid;
    logic        o_s_wlast;
    logic        i_s_wready = 1'b0;
    logic [1:0]  i_s_bresp = '0;
    logic        i_s_bvalid = 1'b0;
    logic [3:0]  i_s_bid = '0;
    logic        o_s_bready;

    ysyx_24110006_axi_arbiter dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_ifu_araddr(i_ifu_araddr), .i_ifu_arsize(i_ifu_arsize), .i_ifu_arvalid(i_ifu_arvalid),
        .o_ifu_arready(o_ifu_arready), .o_ifu_rdata(o_ifu_rdata), .o_ifu_rresp(o_ifu_rresp),
        .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_rlast(o_ifu_rlast), .i_ifu_rready(i_ifu_rready),
        .i_lsu_araddr(i_lsu_araddr), .i_lsu_arsize(i_lsu_arsize), .i_lsu_arvalid(i_lsu_arvalid),
        .o_lsu_arready(o_lsu_arready), .o_lsu_rdata(o_lsu_rdata), .o_lsu_rresp(o_lsu_rresp),
        .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rlast(o_lsu_rlast), .i_lsu_rready(i_lsu_rready),
        .i_lsu_awaddr(i_lsu_awaddr), .i_lsu_awsize(i_lsu_awsize), .i_lsu_awvalid(i_lsu_awvalid),
        .o_lsu_awready(o_lsu_awready), .i_lsu_wdata(i_lsu_wdata), .i_lsu_wstrb(i_lsu_wstrb),
        .i_lsu_wvalid(i_lsu_wvalid), .o_lsu_wready(o_lsu_wready), .o_lsu_bresp(o_lsu_bresp),
        .o_lsu_bvalid(o_lsu_bvalid), .i_lsu_bready(i_lsu_bready),
        .o_s_araddr(o_s_araddr), .o_s_arsize(o_s_arsize), .o_s_arvalid(o_s_arvalid),
        .o_s_arid(o_s_arid), .o_s_arlen(o_s_arlen), .o_s_arburst(o_s_arburst),
        .i_s_arready(i_s_arready), .i_s_rdata(i_s_rdata), .i_s_rresp(i_s_rresp),
        .i_s_rvalid(i_s_rvalid), .i_s_rlast(i_s_rlast), .i_s_rid(i_s_rid), .o_s_rready(o_s_rready),
        .o_s_awaddr(o_s_awaddr), .o_s_awsize(o_s_awsize), .o_s_awvalid(o_s_awvalid),
        .o_s_awid(o_s_awid), .o_s_awlen(o_s_awlen), .o_s_awburst(o_s_awburst),
        .i_s_awready(i_s_awready), .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb),
        .o_s_wvalid(o_s_wvalid), .o_s_wlast(o_s_wlast), .i_s_wready(i_s_wready),
        .i_s_bresp(i_s_bresp), .i_s_bvalid(i_s_bvalid), .i_s_bid(i_s_bid), .o_s_bready(o_s_bready)
    );

    always #5 i_clock = ~i_clock;

    logic any_out;
    assign any_out = |{o_ifu_arready, o_ifu_rdata, o_ifu_rresp, o_ifu_rvalid, o_ifu_rlast,
                       o_lsu_arready, o_lsu_rdata, o_lsu_rresp, o_lsu_rvalid, o_lsu_rlast,
                       o_lsu_awready, o_lsu_wready, o_lsu_bresp, o_lsu_bvalid,
                       o_s_araddr, o_s_arsize, o_s_arvalid, o_s_arid, o_s_arlen, o_s_arburst,
                       o_s_rready, o_s_awaddr, o_s_awsize, o_s_awvalid, o_s_awid, o_s_awlen,
                       o_s_awburst, o_s_wdata, o_s_wstrb, o_s_wvalid, o_s_wlast, o_s_bready};

    typedef struct {
        bit          is_wr;
        bit [3:0]    id;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        int          ar_wait;   // AR (or AW) ready delay in the slave
        int          w_wait;    // W ready delay in the slave
        int          r_wait;    // R (or B) response delay in the slave
    } txn_t;

    txn_t slv_q[$];      // expected slave-side requests, in grant order
    txn_t exp_ifu[$];    // expected IFU R beats
    txn_t exp_lsu_r[$];  // expected LSU R beats
    txn_t exp_lsu_b[$];  // expected LSU B responses
    txn_t ifu_iss[$];
    txn_t lsu_rd_iss[$];
    txn_t lsu_wr_iss[$];

    int n_cmp = 0;
    int n_fail = 0;
    bit flush = 1'b0;
    bit last_rd_m = 1'b1;   // reference round-robin history
    bit prev_r_hs = 1'b0;
    bit prev_b_hs = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic txn_t mk(input bit wr, input bit [3:0] id, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb, input logic [1:0] resp,
                                input int aw, input int ww, input int rw);
        txn_t t;
        t.is_wr = wr; t.id = id; t.addr = addr; t.size = 3'd2; t.data = data;
        t.strb = strb; t.resp = resp; t.ar_wait = aw; t.w_wait = ww; t.r_wait = rw;
        return t;
    endfunction

    // Reference order: a write is served first, then pending reads, a tie
    // going to the master that was not served most recently.
    task automatic run_round(input bit do_ifu, input bit do_lrd, input bit do_wr,
                             input txn_t ti, input txn_t tl, input txn_t tw);
        int cyc;
        if (do_wr) begin
            slv_q.push_back(tw);
            exp_lsu_b.push_back(tw);
        end
        if (do_ifu && do_lrd) begin
            if (last_rd_m) begin slv_q.push_back(ti); slv_q.push_back(tl); last_rd_m = 1'b1; end
            else           begin slv_q.push_back(tl); slv_q.push_back(ti); last_rd_m = 1'b0; end
        end else if (do_ifu) begin
            slv_q.push_back(ti); last_rd_m = 1'b0;
        end else if (do_lrd) begin
            slv_q.push_back(tl); last_rd_m = 1'b1;
        end
        if (do_ifu) exp_ifu.push_back(ti);
        if (do_lrd) exp_lsu_r.push_back(tl);
        @(negedge i_clock); #3;
        if (do_ifu) ifu_iss.push_back(ti);
        if (do_lrd) lsu_rd_iss.push_back(tl);
        if (do_wr)  lsu_wr_iss.push_back(tw);
        cyc = 0;
        while ((slv_q.size() + exp_ifu.size() + exp_lsu_r.size() + exp_lsu_b.size()) != 0 && cyc < 400) begin
            @(negedge i_clock);
            cyc++;
        end
        chk("round_completes", (cyc < 400), 1);
        if (cyc >= 400) begin
            slv_q.delete(); exp_ifu.delete(); exp_lsu_r.delete(); exp_lsu_b.delete();
            flush = 1'b1;
            repeat (3) @(negedge i_clock);
            flush = 1'b0;
        end
        repeat (2) @(negedge i_clock);
    endtask

    // IFU read agent: holds arvalid until accepted, random rready.
    initial begin
        txn_t t;
        bit hs;
        forever begin
            @(negedge i_clock);
            if (ifu_iss.size() > 0 && !flush) begin
                t = ifu_iss.pop_front();
                i_ifu_arvalid = 1'b1; i_ifu_araddr = t.addr; i_ifu_arsize = t.size;
                hs = 1'b0;
                for (int k = 0; k < 300 && !flush; k++) begin
                    #1;
                    if (o_ifu_arready) begin hs = 1'b1; break; end
                    @(negedge i_clock);
                end
                if (hs) @(negedge i_clock);
                i_ifu_arvalid = 1'b0;
                if (hs) begin
                    for (int k = 0; k < 300 && !flush; k++) begin
                        i_ifu_rready = 1'($urandom_range(0, 1));
                        #1;
                        if (o_ifu_rvalid && i_ifu_rready) begin @(negedge i_clock); break; end
                        @(negedge i_clock);
                    end
                end
                i_ifu_rready = 1'b0;
            end
        end
    end

    // LSU read agent.
    initial begin
        txn_t t;
        bit hs;
        forever begin
            @(negedge i_clock);
            if (lsu_rd_iss.size() > 0 && !flush) begin
                t = lsu_rd_iss.pop_front();
                i_lsu_arvalid = 1'b1; i_lsu_araddr = t.addr; i_lsu_arsize = t.size;
                hs = 1'b0;
                for (int k = 0; k < 300 && !flush; k++) begin
                    #1;
                    if (o_lsu_arready) begin hs = 1'b1; break; end
                    @(negedge i_clock);
                end
                if (hs) @(negedge i_clock);
                i_lsu_arvalid = 1'b0;
                if (hs) begin
                    for (int k = 0; k < 300 && !flush; k++) begin
                        i_lsu_rready = 1'($urandom_range(0, 1));
                        #1;
                        if (o_lsu_rvalid && i_lsu_rready) begin @(negedge i_clock); break; end
                        @(negedge i_clock);
                    end
                end
                i_lsu_rready = 1'b0;
            end
        end
    end

    // LSU write agent: AW and W raised together, each dropped on its own handshake.
    initial begin
        txn_t t;
        bit aw_ok, w_ok;
        forever begin
            @(negedge i_clock);
            if (lsu_wr_iss.size() > 0 && !flush) begin
                t = lsu_wr_iss.pop_front();
                i_lsu_awvalid = 1'b1; i_lsu_awaddr = t.addr; i_lsu_awsize = t.size;
                i_lsu_wvalid = 1'b1; i_lsu_wdata = t.data; i_lsu_wstrb = t.strb;
                aw_ok = 1'b0; w_ok = 1'b0;
                for (int k = 0; k < 300 && !flush && !(aw_ok && w_ok); k++) begin
                    #1;
                    if (i_lsu_awvalid && o_lsu_awready) aw_ok = 1'b1;
                    if (i_lsu_wvalid && o_lsu_wready) w_ok = 1'b1;
                    @(negedge i_clock);
                    if (aw_ok) i_lsu_awvalid = 1'b0;
                    if (w_ok) i_lsu_wvalid = 1'b0;
                end
                i_lsu_awvalid = 1'b0; i_lsu_wvalid = 1'b0;
                for (int k = 0; k < 300 && !flush; k++) begin
                    i_lsu_bready = 1'($urandom_range(0, 1));
                    #1;
                    if (o_lsu_bvalid && i_lsu_bready) begin @(negedge i_clock); break; end
                    @(negedge i_clock);
                end
                i_lsu_bready = 1'b0;
            end
        end
    end

    task automatic serve_read(input txn_t t);
        bit done;
        chk("arid", o_s_arid, t.id);
        chk("araddr", o_s_araddr, t.addr);
        chk("arsize", o_s_arsize, t.size);
        chk("arlen_arburst", {o_s_arlen, o_s_arburst}, {8'd0, 2'b01});
        for (int k = 0; k <= t.ar_wait && !flush; k++) @(negedge i_clock);
        i_s_arready = 1'b1;
        #1;
        if (!flush) chk("arvalid_held", o_s_arvalid, 1);
        @(negedge i_clock);
        i_s_arready = 1'b0;
        for (int k = 0; k < t.r_wait && !flush; k++) @(negedge i_clock);
        if (!flush) begin
            i_s_rvalid = 1'b1; i_s_rdata = t.data; i_s_rresp = t.resp; i_s_rlast = 1'b1; i_s_rid = t.id;
            done = 1'b0;
            for (int k = 0; k < 300 && !flush; k++) begin
                #1;
                if (o_s_rready) begin done = 1'b1; break; end
                @(negedge i_clock);
            end
            if (!flush) chk("r_accepted", done, 1);
            if (done) @(negedge i_clock);
        end
        i_s_rvalid = 1'b0; i_s_rdata = '0; i_s_rresp = '0; i_s_rlast = 1'b0; i_s_rid = '0;
    endtask

    task automatic serve_write(input txn_t t);
        bit aw_hs, w_hs, reissue, done;
        int last_c;
        chk("awid", o_s_awid, 4'd1);
        chk("awaddr", o_s_awaddr, t.addr);
        chk("awsize", o_s_awsize, t.size);
        chk("awlen_awburst", {o_s_awlen, o_s_awburst}, {8'd0, 2'b01});
        chk("wvalid", o_s_wvalid, 1);
        chk("wdata", o_s_wdata, t.data);
        chk("wstrb", o_s_wstrb, t.strb);
        chk("wlast", o_s_wlast, 1);
        aw_hs = 1'b0; w_hs = 1'b0; reissue = 1'b0;
        last_c = (t.ar_wait > t.w_wait ? t.ar_wait : t.w_wait) + 1;
        for (int c = 0; c <= last_c && !flush; c++) begin
            @(negedge i_clock);
            i_s_awready = (c == t.ar_wait);
            i_s_wready  = (c == t.w_wait);
            #1;
            if (aw_hs && o_s_awvalid) reissue = 1'b1;
            if (w_hs && o_s_wvalid) reissue = 1'b1;
            if (i_s_awready && o_s_awvalid) aw_hs = 1'b1;
            if (i_s_wready && o_s_wvalid) w_hs = 1'b1;
        end
        i_s_awready = 1'b0; i_s_wready = 1'b0;
        if (!flush) chk("aw_w_once", {aw_hs, w_hs, reissue}, 3'b110);
        for (int k = 0; k <= t.r_wait && !flush; k++) @(negedge i_clock);
        if (!flush) begin
            i_s_bvalid = 1'b1; i_s_bresp = t.resp; i_s_bid = 4'd1;
            done = 1'b0;
            for (int k = 0; k < 300 && !flush; k++) begin
                #1;
                if (o_s_bready) begin done = 1'b1; break; end
                @(negedge i_clock);
            end
            if (!flush) chk("b_accepted", done, 1);
            if (done) @(negedge i_clock);
        end
        i_s_bvalid = 1'b0; i_s_bresp = '0; i_s_bid = '0;
    endtask

    // Slave model: checks each granted request against the reference order.
    initial begin
        txn_t t;
        forever begin
            @(negedge i_clock); #1;
            if (!flush && i_reset_n && (o_s_arvalid || o_s_awvalid)) begin
                if (slv_q.size() == 0) begin
                    chk("unexpected_slave_req", {o_s_arvalid, o_s_awvalid}, 2'b00);
                end else begin
                    t = slv_q.pop_front();
                    $display("slave txn: %s id=%0d addr=0x%08h data=0x%08h resp=%0d",
                             t.is_wr ? "WR" : "RD", t.id, t.addr, t.data, t.resp);
                    chk("req_kind", {o_s_arvalid, o_s_awvalid}, t.is_wr ? 2'b01 : 2'b10);
                    if (t.is_wr) serve_write(t);
                    else         serve_read(t);
                end
            end
        end
    end

    // Monitor: pops expected responses at each master-side handshake.
    initial begin
        txn_t e;
        forever begin
            @(negedge i_clock); #2;
            if (i_reset_n && !flush) begin
                if (prev_r_hs) chk("idle_after_r", {o_s_rready, o_s_arvalid, o_ifu_arready, o_lsu_arready}, 0);
                if (prev_b_hs) chk("idle_after_b", {o_s_bready, o_s_awvalid, o_s_wvalid, o_lsu_bvalid}, 0);
                prev_r_hs = 1'b0;
                prev_b_hs = 1'b0;
                if (o_ifu_rvalid && i_ifu_rready) begin
                    prev_r_hs = 1'b1;
                    if (exp_ifu.size() == 0) chk("ifu_r_unexpected", 1, 0);
                    else begin
                        e = exp_ifu.pop_front();
                        chk("ifu_rdata", o_ifu_rdata, e.data);
                        chk("ifu_rresp", o_ifu_rresp, e.resp);
                        chk("ifu_rlast", o_ifu_rlast, 1);
                        chk("lsu_rvalid_quiet", o_lsu_rvalid, 0);
                    end
                end
                if (o_lsu_rvalid && i_lsu_rready) begin
                    prev_r_hs = 1'b1;
                    if (exp_lsu_r.size() == 0) chk("lsu_r_unexpected", 1, 0);
                    else begin
                        e = exp_lsu_r.pop_front();
                        chk("lsu_rdata", o_lsu_rdata, e.data);
                        chk("lsu_rresp", o_lsu_rresp, e.resp);
                        chk("lsu_rlast", o_lsu_rlast, 1);
                        chk("ifu_rvalid_quiet", o_ifu_rvalid, 0);
                    end
                end
                if (o_lsu_bvalid && i_lsu_bready) begin
                    prev_b_hs = 1'b1;
                    if (exp_lsu_b.size() == 0) chk("lsu_b_unexpected", 1, 0);
                    else begin
                        e = exp_lsu_b.pop_front();
                        chk("lsu_bresp", o_lsu_bresp, e.resp);
                    end
                end
            end
        end
    end

    // Main sequence: directed scenarios, mid-transaction reset, random rounds.
    initial begin
        txn_t ti, tl, tw, d;
        bit m_ifu, m_lrd, m_wr;
        d = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        #1 i_reset_n = 1'b0;
        #2 chk("reset_outputs_zero", any_out, 0);
        repeat (2) @(negedge i_clock);
        chk("reset_held_outputs_zero", any_out, 0);
        i_reset_n = 1'b1;
        @(negedge i_clock);

        // simultaneous reads after reset: IFU first, then LSU, twice
        run_round(1, 1, 0, mk(0, 0, 32'h8000_0100, 32'h1111_0001, 0, 0, 0, 0, 0),
                           mk(0, 1, 32'h0F00_0020, 32'h2222_0002, 0, 0, 1, 0, 1), d);
        run_round(1, 1, 0, mk(0, 0, 32'h8000_0104, 32'h1111_0003, 0, 0, 1, 0, 0),
                           mk(0, 1, 32'h0F00_0024, 32'h2222_0004, 0, 0, 0, 0, 2), d);
        // IFU fetch with two response waits
        run_round(1, 0, 0, mk(0, 0, 32'h8000_0000, 32'h0000_0413, 0, 0, 0, 0, 2), d, d);
        // write beats a pending IFU read
        run_round(1, 0, 1, mk(0, 0, 32'h8000_0008, 32'h0000_0513, 0, 0, 0, 0, 0), d,
                           mk(1, 1, 32'hA000_03F8, 32'hDEAD_BEEF, 4'b1100, 0, 1, 1, 1));
        // W accepted two cycles before AW
        run_round(0, 0, 1, d, d, mk(1, 1, 32'hA000_0400, 32'h0BAD_F00D, 4'b1111, 0, 2, 0, 0));
        // error response on an LSU read passes through
        run_round(0, 1, 0, d, mk(0, 1, 32'h1000_0000, 32'hCAFE_0000, 0, 2'b10, 0, 0, 1), d);

        // reset while the LSU read waits for its data
        tl = mk(0, 1, 32'h3000_0010, 32'h5555_AAAA, 0, 0, 0, 0, 12);
        slv_q.push_back(tl);
        @(negedge i_clock); #3;
        lsu_rd_iss.push_back(tl);
        repeat (5) @(negedge i_clock);
        #2;
        chk("pre_reset_lsu_grant", {o_s_arid, o_s_arburst, o_lsu_rvalid}, {4'd1, 2'b01, 1'b0});
        flush = 1'b1;
        i_reset_n = 1'b0;
        #1 chk("async_reset_outputs_zero", any_out, 0);
        repeat (3) @(negedge i_clock);
        chk("reset_drops_response", any_out, 0);
        i_reset_n = 1'b1;
        last_rd_m = 1'b1;
        slv_q.delete();
        repeat (2) @(negedge i_clock);
        flush = 1'b0;
        run_round(1, 0, 0, mk(0, 0, 32'h8000_0010, 32'h0000_0093, 0, 0, 0, 0, 1), d, d);

        // random rounds
        for (int r = 0; r < 40; r++) begin
            m_ifu = 1'($urandom_range(0, 1));
            m_lrd = 1'($urandom_range(0, 1));
            m_wr  = 1'($urandom_range(0, 1));
            if (!(m_ifu || m_lrd || m_wr)) m_ifu = 1'b1;
            ti = mk(0, 0, $urandom, $urandom, 0, 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 3)));
            ti.size = 3'($urandom_range(0, 2));
            tl = mk(0, 1, $urandom, $urandom, 0, 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 3)));
            tl.size = 3'($urandom_range(0, 2));
            tw = mk(1, 1, $urandom, $urandom, 4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            tw.size = 3'($urandom_range(0, 2));
            run_round(m_ifu, m_lrd, m_wr, ti, tl, tw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_24110006_axi_arbiter.md
# ysyx_24110006_axi_arbiter

Two-master, one-slave AXI4 arbiter placed directly downstream of the LSU and IFU master ports, presenting a single AXI master interface to the memory/peripheral side. It serialises single-beat transactions (len = 0), one outstanding transaction in total. Grant is registered, with round-robin between the two read requesters. The LSU is the only master allowed to write.

## Interface
- No parameters; address/data 32 bits, id 4 bits, single-beat only.
- i_clock  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_ifu_araddr / i_ifu_arsize / i_ifu_arvalid  in  32/3/1  IFU read address channel
- o_ifu_arready  out  1  IFU AR accept
- o_ifu_rdata / o_ifu_rresp / o_ifu_rvalid / o_ifu_rlast  out  32/2/1/1  IFU read data channel
- i_ifu_rready  in  1  IFU R accept
- i_lsu_araddr / i_lsu_arsize / i_lsu_arvalid  in  32/3/1  LSU read address channel
- o_lsu_arready  out  1  LSU AR accept
- o_lsu_rdata / o_lsu_rresp / o_lsu_rvalid / o_lsu_rlast  out  32/2/1/1  LSU read data channel
- i_lsu_rready  in  1  LSU R accept
- i_lsu_awaddr / i_lsu_awsize / i_lsu_awvalid  in  32/3/1  LSU write address channel
- o_lsu_awready  out  1  LSU AW accept
- i_lsu_wdata / i_lsu_wstrb / i_lsu_wvalid  in  32/4/1  LSU write data channel
- o_lsu_wready  out  1  LSU W accept
- o_lsu_bresp / o_lsu_bvalid  out  2/1  LSU write response
- i_lsu_bready  in  1  LSU B accept
- o_s_araddr, o_s_arsize, o_s_arvalid, o_s_arid, o_s_arlen, o_s_arburst  out  32/3/1/4/8/2  slave AR
- i_s_arready  in  1
- i_s_rdata, i_s_rresp, i_s_rvalid, i_s_rlast, i_s_rid  in  32/2/1/1/4  slave R
- o_s_rready  out  1
- o_s_awaddr, o_s_awsize, o_s_awvalid, o_s_awid, o_s_awlen, o_s_awburst  out  32/3/1/4/8/2  slave AW
- i_s_awready  in  1
- o_s_wdata, o_s_wstrb, o_s_wvalid, o_s_wlast  out  32/4/1/1  slave W
- i_s_wready  in  1
- i_s_bresp, i_s_bvalid, i_s_bid  in  2/1/4  slave B
- o_s_bready  out  1

## Operation
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR; one register `last_rd` (0 = IFU, 1 = LSU) for round-robin.
- IDLE: every ready and slave valid output is 0. Arbitration samples the request valids:
  - i_lsu_awvalid -> LSU_WR; writes win over any read.
  - else both read valids -> grant the master not equal to last_rd.
  - else the single read requester -> its RD state.
- IFU_RD / LSU_RD: AR and R channels of the granted master are wired combinationally to the slave (valid/addr/size forward, ready/data/resp/last back).
  - o_s_arid = 0 for IFU, 1 for LSU. arlen = 0, arburst = 2'b01.
  - Non-granted master sees arready = 0 and rvalid = 0.
- LSU_WR: AW, W and B channels are wired through. AW and W may complete in either order or in the same cycle. o_s_awid = 1, o_s_wlast = 1.
- Exit: RD state -> IDLE on i_s_rvalid && granted rready. WR -> IDLE on i_s_bvalid && i_lsu_bready. last_rd updates on read completion.
- rresp/bresp pass through unmodified, including SLVERR/DECERR. rid/bid are ignored.
- The AR handshake must occur before R is forwarded; R beats arriving before AR completion are not expected and are forwarded as-is.

## Timing
- Reset (async assert, released on clock edge): state IDLE, last_rd = 1 (IFU wins the first tie), all outputs 0.
- Grant latency: a request valid seen in IDLE at edge N produces the slave-side valid in cycle N+1. Minimum read is 3 cycles (IDLE, AR, R) with a zero-wait slave.
- No bubble removal: after completion, at least one IDLE cycle precedes the next grant.
- Master valids may drop only after handshake (AXI rule). The arbiter never drops a forwarded valid.
- Reset asserted mid-transaction: immediate return to IDLE; outstanding slave response is dropped, ready outputs 0.

## Test plan
- IFU read of 0x8000_0000, slave returns 0x0000_0413 after 2 waits -> o_ifu_rdata = 0x0000_0413, o_s_arid = 0, FSM back to IDLE the cycle after the R handshake.
- IFU and LSU arvalid in the same cycle after reset -> IFU granted first, LSU second; repeat both -> order alternates (IFU, LSU, IFU, LSU).
- LSU write 0xDEADBEEF, wstrb 0b1100 to 0xA000_03F8 while the IFU read is pending -> write granted first, o_s_wstrb = 0b1100, o_lsu_bvalid pulses, then the IFU read is served.
- Slave accepts W two cycles before AW -> single B forwarded; neither channel re-issued.
- Slave returns rresp = 2'b10 on an LSU read -> o_lsu_rresp = 2'b10, o_ifu_rvalid stays 0.
- i_reset_n pulsed low while in LSU_RD before rvalid -> all outputs 0 asynchronously; after release, a new IFU read completes normally.
